// File: rtl/sram_march_bist.sv
// sram_march_bist
// Built-in self-test initiator for one port of dual_port_sram. On start it
// runs a four-element March sequence (w0 up; r0,w1 up; r1,w0 down; r0 up),
// compares every read against its expected value and reports the outcome.
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous, active-high
//   start          begin a test; honoured only in IDLE or DONE
//   sram_rwenable  1 = write, 0 = read (registered)
//   sram_addr      SRAM address (registered)
//   sram_data      SRAM write data, 0 on reads (registered)
//   sram_rdata     SRAM read data, valid one edge after the command
//   busy           test in progress
//   done           test complete, results valid (level)
//   pass           done with zero miscompares
//   fail_addr      address of the first miscompare
//   fail_data      data read at the first miscompare
//   err_count      saturating miscompare count
module sram_march_bist #(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 64,
    parameter int ADDR_SIZE = 8,
    parameter int ERR_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 sram_rwenable,
    output logic [ADDR_SIZE-1:0] sram_addr,
    output logic [RAM_WIDTH-1:0] sram_data,
    input  logic [RAM_WIDTH-1:0] sram_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_SIZE-1:0] fail_addr,
    output logic [RAM_WIDTH-1:0] fail_data,
    output logic [ERR_W-1:0]     err_count
);

    typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, DRAIN, DONE} state_t;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(RAM_DEPTH - 1);

    // State register holds the element of the command currently on the bus.
    state_t               state, state_nxt;
    logic [ADDR_SIZE-1:0] addr_cnt, addr_nxt;
    logic                 phase, phase_nxt;       // M1/M2: 0 = read op, 1 = write op
    logic                 drain_cnt, drain_nxt;

    // Command about to be registered, decoded from the next state.
    logic                 cmd_rw;
    logic [ADDR_SIZE-1:0] cmd_addr;
    logic [RAM_WIDTH-1:0] cmd_data;
    logic                 rd_issue;
    logic [RAM_WIDTH-1:0] rd_exp;

    // Two-stage compare pipeline matching the SRAM's registered read latency.
    logic                 s1_valid, s2_valid;
    logic [ADDR_SIZE-1:0] s1_addr, s2_addr;
    logic [RAM_WIDTH-1:0] s1_exp, s2_exp;

    logic start_ok;
    logic miscompare;

    assign start_ok   = start && (state == IDLE || state == DONE);
    assign miscompare = s2_valid && (sram_rdata != s2_exp);
    assign busy       = (state != IDLE) && (state != DONE);
    assign done       = (state == DONE);

    // Next-state logic: transitions happen at the terminal address, so the
    // counter never presents a wrapped or underflowed value on the bus.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves it unassigned and no latch is inferred.
        state_nxt = state;
        addr_nxt  = addr_cnt;
        phase_nxt = phase;
        drain_nxt = drain_cnt;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = M0;
                    addr_nxt  = '0;
                    phase_nxt = 1'b0;
                end
            end
            M0: begin
                if (addr_cnt == LAST_ADDR) begin
                    state_nxt = M1;
                    addr_nxt  = '0;
                    phase_nxt = 1'b0;
                end else begin
                    addr_nxt = addr_cnt + 1'b1;
                end
            end
            M1: begin
                if (!phase) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    if (addr_cnt == LAST_ADDR) begin
                        state_nxt = M2;
                        addr_nxt  = LAST_ADDR;
                    end else begin
                        addr_nxt = addr_cnt + 1'b1;
                    end
                end
            end
            M2: begin
                if (!phase) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    if (addr_cnt == '0) begin
                        state_nxt = M3;
                    end else begin
                        addr_nxt = addr_cnt - 1'b1;
                    end
                end
            end
            M3: begin
                if (addr_cnt == LAST_ADDR) begin
                    state_nxt = DRAIN;
                    addr_nxt  = '0;
                    drain_nxt = 1'b0;
                end else begin
                    addr_nxt = addr_cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt) state_nxt = DONE;
                else           drain_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: the command and its expected read value for the next edge.
    always_comb begin
        cmd_rw   = 1'b0;
        cmd_addr = '0;
        cmd_data = '0;
        rd_issue = 1'b0;
        rd_exp   = '0;
        case (state_nxt)
            M0: begin
                cmd_rw   = 1'b1;
                cmd_addr = addr_nxt;
            end
            M1: begin
                cmd_addr = addr_nxt;
                if (phase_nxt) begin
                    cmd_rw   = 1'b1;
                    cmd_data = '1;
                end else begin
                    rd_issue = 1'b1;
                end
            end
            M2: begin
                cmd_addr = addr_nxt;
                if (phase_nxt) begin
                    cmd_rw = 1'b1;
                end else begin
                    rd_issue = 1'b1;
                    rd_exp   = '1;
                end
            end
            M3: begin
                cmd_addr = addr_nxt;
                rd_issue = 1'b1;
            end
            default: ;
        endcase
    end

    // State, command and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            addr_cnt      <= '0;
            phase         <= 1'b0;
            drain_cnt     <= 1'b0;
            sram_rwenable <= 1'b0;
            sram_addr     <= '0;
            sram_data     <= '0;
            s1_valid      <= 1'b0;
            s1_addr       <= '0;
            s1_exp        <= '0;
            s2_valid      <= 1'b0;
            s2_addr       <= '0;
            s2_exp        <= '0;
            pass          <= 1'b0;
            fail_addr     <= '0;
            fail_data     <= '0;
            err_count     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state         <= state_nxt;
            addr_cnt      <= addr_nxt;
            phase         <= phase_nxt;
            drain_cnt     <= drain_nxt;
            sram_rwenable <= cmd_rw;
            sram_addr     <= cmd_addr;
            sram_data     <= cmd_data;
            s1_valid      <= rd_issue;
            s1_addr       <= cmd_addr;
            s1_exp        <= rd_exp;
            if (start_ok) begin
                s2_valid  <= 1'b0;
                s2_addr   <= '0;
                s2_exp    <= '0;
                pass      <= 1'b0;
                fail_addr <= '0;
                fail_data <= '0;
                err_count <= '0;
            end else begin
                s2_valid <= s1_valid;
                s2_addr  <= s1_addr;
                s2_exp   <= s1_exp;
                if (miscompare) begin
                    if (err_count == '0) begin
                        fail_addr <= s2_addr;
                        fail_data <= sram_rdata;
                    end
                    if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
                end
                // The last compare lands one edge before DONE, so err_count is final here.
                if (state == DRAIN && state_nxt == DONE) pass <= (err_count == '0);
            end
        end
    end

endmodule

// File: tb/tb_sram_march_bist.sv
// Testbench for sram_march_bist: a behavioural dual_port_sram port with an
// optional stuck-at-1 on bit 0 of reads from address 5, and a scoreboard
// queue holding the full expected March command trace for each run.
module tb_sram_march_bist;

    localparam int N    = 64;
    localparam int RUNC = 6 * N + 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       sram_rwenable;
    logic [7:0] sram_addr;
    logic [7:0] sram_data;
    logic [7:0] sram_rdata;
    logic       busy, done, pass;
    logic [7:0] fail_addr, fail_data, err_count;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:N-1];
    logic        fault_en;
    logic [16:0] exp_q[$];
    logic [16:0] mon_e;
    int          cyc;

    always #5 clk = ~clk;

    sram_march_bist #(
        .RAM_WIDTH(8), .RAM_DEPTH(N), .ADDR_SIZE(8), .ERR_W(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .sram_rwenable(sram_rwenable),
        .sram_addr    (sram_addr),
        .sram_data    (sram_data),
        .sram_rdata   (sram_rdata),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_addr    (fail_addr),
        .fail_data    (fail_data),
        .err_count    (err_count)
    );

    // SRAM port model: registered output, write-through on writes.
    always @(posedge clk) begin
        if (sram_rwenable) begin
            mem[sram_addr[5:0]] <= sram_data;
            sram_rdata          <= sram_data;
        end else begin
            sram_rdata <= mem[sram_addr[5:0]] |
                          ((fault_en && sram_addr == 8'd5) ? 8'h01 : 8'h00);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Expected March command trace {rw, addr, data}, one entry per edge.
    task automatic push_trace();
        for (int a = 0; a < N; a++) exp_q.push_back({1'b1, 8'(a), 8'h00});
        for (int a = 0; a < N; a++) begin
            exp_q.push_back({1'b0, 8'(a), 8'h00});
            exp_q.push_back({1'b1, 8'(a), 8'hFF});
        end
        for (int a = N - 1; a >= 0; a--) begin
            exp_q.push_back({1'b0, 8'(a), 8'h00});
            exp_q.push_back({1'b1, 8'(a), 8'h00});
        end
        for (int a = 0; a < N; a++) exp_q.push_back({1'b0, 8'(a), 8'h00});
    endtask

    // Command monitor: pops one expected command per edge while a trace is pending.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("cmd", {15'd0, sram_rwenable, sram_addr, sram_data}, {15'd0, mon_e});
        end
    end

    // Start a run; return the cycle count from the start edge until done
    // (or until abort_at). poke adds start pulses at t0+10 and t0+300.
    task automatic run_test(input bit poke, input int abort_at, output int n);
        int busy_drop;
        busy_drop = 0;
        @(negedge clk);
        push_trace();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        check("t0_busy", busy, 1);
        check("t0_done_clr", done, 0);
        check("t0_pass_clr", pass, 0);
        check("t0_err_clr", err_count, 0);
        check("t0_faddr_clr", fail_addr, 0);
        check("t0_fdata_clr", fail_data, 0);
        while (!done && n < RUNC + 100 && (abort_at == 0 || n < abort_at)) begin
            @(posedge clk);
            #1;
            n++;
            if (!done && !busy) busy_drop++;
            start = poke && (n == 9 || n == 299);
        end
        start = 1'b0;
        check("busy_hold", busy_drop, 0);
        if (abort_at == 0) begin
            check("done_cycle", n, RUNC);
            check("busy_after_done", busy, 0);
            check("bus_idle_done", {sram_rwenable, sram_addr, sram_data}, 0);
            check("trace_consumed", exp_q.size(), 0);
        end
    endtask

    task automatic check_results(input logic exp_pass, input logic [7:0] exp_err,
                                 input logic [7:0] exp_fa, input logic [7:0] exp_fd);
        check("res_done", done, 1);
        check("res_pass", pass, exp_pass);
        check("res_err", err_count, exp_err);
        check("res_faddr", fail_addr, exp_fa);
        check("res_fdata", fail_data, exp_fd);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        fault_en = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {sram_rwenable, sram_addr, sram_data, busy, done, pass,
                              fail_addr, fail_data, err_count}, 0);
        @(negedge clk) reset = 1'b0;
        repeat (2) @(posedge clk);

        // Fault-free run, then DONE must hold.
        run_test(1'b0, 0, cyc);
        check_results(1'b1, 8'd0, 8'd0, 8'd0);
        repeat (5) @(posedge clk);
        #1;
        check("done_hold", {done, pass, busy}, 3'b110);

        // Start pulses while busy are ignored.
        run_test(1'b1, 0, cyc);
        check_results(1'b1, 8'd0, 8'd0, 8'd0);

        // Reset during M2: everything clears at once, no further commands.
        run_test(1'b0, 3 * N + 10, cyc);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_outputs", {sram_rwenable, sram_addr, sram_data, busy, done, pass,
                                 fail_addr, fail_data, err_count}, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("midrst_no_cmd", sram_rwenable, 0);
        end
        @(negedge clk) reset = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("post_rst_idle", {sram_rwenable, busy}, 0);
        end
        run_test(1'b0, 0, cyc);
        check_results(1'b1, 8'd0, 8'd0, 8'd0);

        // Stuck-at-1 on bit 0 of address 5: one miscompare in M1, one in M3.
        fault_en = 1'b1;
        run_test(1'b0, 0, cyc);
        check_results(1'b0, 8'd2, 8'd5, 8'h01);

        // Restart from DONE with the fault removed.
        fault_en = 1'b0;
        run_test(1'b0, 0, cyc);
        check_results(1'b1, 8'd0, 8'd0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

Built-in self-test initiator for one port of the on-chip `dual_port_sram`.
- On `start`, drives that port's `rwenable`/`addr`/`data` through a four-element March sequence and compares every read against its expected value.
- Reports pass/fail, the first failing address and data, and a saturating error count.
- Sits between the SRAM port and the system controller. The SRAM's other port must stay idle (`rwenable` = 0) while `busy` = 1.

## Interface
- `RAM_WIDTH`, 8: SRAM data width.
- `RAM_DEPTH`, 64: number of words tested; addresses 0..`RAM_DEPTH`-1.
- `ADDR_SIZE`, 8: SRAM address width; `RAM_DEPTH` ≤ 2^`ADDR_SIZE`.
- `ERR_W`, 8: width of `err_count`.
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  begin a test; honoured only in IDLE or DONE.
- `sram_rwenable`  out  1  1 = write, 0 = read; goes to the SRAM `rwenable` port.
- `sram_addr`  out  `ADDR_SIZE`  SRAM address.
- `sram_data`  out  `RAM_WIDTH`  SRAM write data.
- `sram_rdata`  in  `RAM_WIDTH`  SRAM `outputData`, registered in the SRAM one edge after the command.
- `busy`  out  1  test in progress.
- `done`  out  1  level; test complete, results valid.
- `pass`  out  1  1 when `done` = 1 and `err_count` = 0.
- `fail_addr`  out  `ADDR_SIZE`  address of the first miscompare.
- `fail_data`  out  `RAM_WIDTH`  data read at the first miscompare.
- `err_count`  out  `ERR_W`  miscompare count; saturates at all-ones.

## Operation
- **States:** IDLE, M0, M1, M2, M3, DRAIN, DONE. N = `RAM_DEPTH`. Z = all-zeros. O = all-ones.
- **M0 (w Z, ascending):** one write per cycle, addresses 0..N-1.
- **M1 (r Z, w O, ascending):** two cycles per address: read with expected value Z, then write O.
- **M2 (r O, w Z, descending):** addresses N-1 down to 0; read with expected value O, then write Z.
- **M3 (r Z, ascending):** one read per cycle, addresses 0..N-1.
- **DRAIN:** 2 cycles, no commands issued, lets the last read finish comparing. Then go to DONE.
- **Command registers:** `sram_rwenable`, `sram_addr` and `sram_data` are registered. In IDLE, DRAIN and DONE they are 0/0/0. `sram_data` = 0 on reads.
- **Compare pipeline:**
  - Issuing a read sets stage-1 {valid, addr, exp}.
  - Stage-1 moves to stage-2 on the next edge.
  - While stage-2 is valid, `sram_rdata` is compared with stage-2 exp. A miscompare is registered on the following edge.
  - Write-through data returned on write cycles is never compared.
- **On miscompare:**
  - `err_count` += 1, saturating at all-ones.
  - If this is the first error, capture `fail_addr` and `fail_data`; later errors never overwrite them.
- **Start handling:**
  - `start` in IDLE or DONE clears `done`, `pass`, `err_count`, `fail_addr`, `fail_data` and the pipeline, then enters M0.
  - `start` while `busy` = 1 is ignored.
- **DONE:** holds `done` = 1 and `pass` until the next `start` or reset.
- **Address counter:** sized `ADDR_SIZE`. Wrap or underflow past the ends never reaches the bus, because state transitions happen at the terminal address (N-1 ascending, 0 descending).

## Timing
- **Reset:** asynchronous; all outputs go to 0, state goes to IDLE, the pipeline is cleared. It takes effect mid-test with no further SRAM commands. SRAM contents are left undefined.
- **Start edge t0:** `start` is sampled at edge t0. At t0, `busy` goes to 1 and the first command (write, addr 0, data Z) is registered.
- **Command window:** commands occupy edges t0 .. t0+6N-1, one per cycle with no bubbles. Total = N + 2N + 2N + N = 6N cycles.
- **Stage boundaries:**
  - M1 starts at edge t0+N.
  - M2 starts at edge t0+3N.
  - M3 starts at edge t0+5N.
- **Read latency:** a read issued at edge t is compared against `sram_rdata` at edge t+2.
- **Completion:** at edge t0+6N+2, `busy` goes to 0, `done` goes to 1, and `pass` is registered from the final `err_count`.
- **N = 64:** `done` rises 386 cycles after t0.

## Test plan
- **Fault-free run:** `dual_port_sram` model with depth 64; reset, pulse `start` -> `done` = 1 at t0+386, `pass` = 1, `err_count` = 0, `busy` low only after t0+386.
- **Command trace:**
  - Edges t0..t0+2 -> rw = 1, addr 0/1/2, data 00.
  - Edge t0+64 -> read addr 0. Edge t0+65 -> write addr 0, data FF.
  - Edge t0+192 -> read addr 63 (first M2 op).
- **Stuck-at fault:** bench forces bit 0 of reads from address 5 to 1 -> M1 and M3 each miscompare once; `err_count` = 2, `fail_addr` = 5, `fail_data` = 8'h01, `pass` = 0.
- **Start while busy:** extra `start` pulses at t0+10 and t0+300 -> ignored; `done` still rises at t0+386 with identical results.
- **Reset mid-test:** assert `reset` during M2 -> all outputs 0 immediately, state IDLE, no SRAM writes after reset; a later `start` completes with `pass` = 1.
- **Restart from DONE:** after a failing run (`err_count` = 2), `start` with the fault removed -> `done`, `err_count` and the fail registers clear at the start edge; run ends with `pass` = 1 and `err_count` = 0.
